// File: rtl/feature_seq_pkg.sv
// Shared types and default sizing for the 2-D feature index sequencer.
package feature_seq_pkg;

    localparam int DEF_MAX_ROWS = 6;
    localparam int DEF_MAX_COLS = 8;
    localparam int DEF_ROW_W    = $clog2(DEF_MAX_ROWS + 1);
    localparam int DEF_COL_W    = $clog2(DEF_MAX_COLS + 1);
    localparam int DEF_ADDR_W   = $clog2(DEF_MAX_ROWS * DEF_MAX_COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DEF_ROW_W-1:0]  row;
        logic [DEF_COL_W-1:0]  col;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  row_last;
        logic                  mat_last;
    } seq_tuple_t;

endpackage

// File: rtl/feature_index_sequencer_if.sv
// Control and address-stream bundle of the feature index sequencer.
// FEATURE_SEQ_COL_MAJOR_EN adds the col_major order select.
interface feature_index_sequencer_if #(
    parameter int ROW_W  = 3,
    parameter int COL_W  = 4,
    parameter int ADDR_W = 6
) ();
    logic              start;
    logic [ROW_W-1:0]  num_rows;
    logic [COL_W-1:0]  num_cols;
`ifdef FEATURE_SEQ_COL_MAJOR_EN
    logic              col_major;
`endif
    logic              addr_ready;
    logic              addr_valid;
    logic [ROW_W-1:0]  row_idx;
    logic [COL_W-1:0]  col_idx;
    logic [ADDR_W-1:0] lin_addr;
    logic              row_last;
    logic              mat_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, num_rows, num_cols, addr_ready,
`ifdef FEATURE_SEQ_COL_MAJOR_EN
        input  col_major,
`endif
        output addr_valid, row_idx, col_idx, lin_addr, row_last, mat_last, busy, done
    );

    modport slave (
        output start, num_rows, num_cols, addr_ready,
`ifdef FEATURE_SEQ_COL_MAJOR_EN
        output col_major,
`endif
        input  addr_valid, row_idx, col_idx, lin_addr, row_last, mat_last, busy, done
    );
endinterface

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..limit on en, wraps to 0 after limit, clr forces 0.
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);
    assign at_limit = (count == limit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_limit ? '0 : count + W'(1);
        end
    end
endmodule

// File: rtl/feature_index_sequencer.sv
// Walks a runtime-sized rows x cols feature matrix, one (row, col, addr) tuple per beat.
// FEATURE_SEQ_COL_MAJOR_EN enables the optional column-major order.
module feature_index_sequencer
    import feature_seq_pkg::*;
#(
    parameter int MAX_ROWS = DEF_MAX_ROWS,
    parameter int MAX_COLS = DEF_MAX_COLS,
    parameter int ROW_W    = $clog2(MAX_ROWS + 1),
    parameter int COL_W    = $clog2(MAX_COLS + 1),
    parameter int ADDR_W   = $clog2(MAX_ROWS * MAX_COLS)
) (
    input logic                        clk,
    input logic                        reset,
    feature_index_sequencer_if.master  bus
);
    localparam int CNT_W = (ROW_W > COL_W) ? ROW_W : COL_W;

    seq_state_e        state_q, state_d;
    logic [ROW_W-1:0]  rows_q, rows_in;
    logic [COL_W-1:0]  cols_q, cols_in;
    logic              col_major_q, col_major_in;
    logic [ADDR_W-1:0] lin_q;
    logic              start_acc, zero_size, beat, is_run;
    logic [CNT_W-1:0]  inner_limit, outer_limit, inner_count, outer_count;
    logic              inner_at, outer_at;

    function automatic logic [ROW_W-1:0] clamp_rows(input logic [ROW_W-1:0] n);
        return (n > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : n;
    endfunction

    function automatic logic [COL_W-1:0] clamp_cols(input logic [COL_W-1:0] n);
        return (n > COL_W'(MAX_COLS)) ? COL_W'(MAX_COLS) : n;
    endfunction

    assign rows_in = clamp_rows(bus.num_rows);
    assign cols_in = clamp_cols(bus.num_cols);
`ifdef FEATURE_SEQ_COL_MAJOR_EN
    assign col_major_in = bus.col_major;
`else
    assign col_major_in = 1'b0;
`endif

    assign is_run    = (state_q == RUN);
    assign start_acc = (state_q == IDLE) && bus.start;
    assign zero_size = (rows_in == '0) || (cols_in == '0);
    assign beat      = is_run && bus.addr_ready;

    // Inner counter sweeps the fast dimension; outer advances when inner wraps.
    assign inner_limit = col_major_q ? CNT_W'(rows_q) - CNT_W'(1) : CNT_W'(cols_q) - CNT_W'(1);
    assign outer_limit = col_major_q ? CNT_W'(cols_q) - CNT_W'(1) : CNT_W'(rows_q) - CNT_W'(1);

    wrap_counter #(.W(CNT_W)) u_inner (
        .clk(clk), .reset(reset), .en(beat), .clr(start_acc),
        .limit(inner_limit), .count(inner_count), .at_limit(inner_at)
    );

    wrap_counter #(.W(CNT_W)) u_outer (
        .clk(clk), .reset(reset), .en(beat && inner_at), .clr(start_acc),
        .limit(outer_limit), .count(outer_count), .at_limit(outer_at)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            col_major_q <= 1'b0;
            lin_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                rows_q      <= rows_in;
                cols_q      <= cols_in;
                col_major_q <= col_major_in;
                lin_q       <= '0;
            end else if (beat) begin
                // Column-major rewinds to the top of the next column, whose address is its column index.
                if (inner_at && outer_at)
                    lin_q <= '0;
                else if (!col_major_q)
                    lin_q <= lin_q + ADDR_W'(1);
                else if (inner_at)
                    lin_q <= ADDR_W'(outer_count) + ADDR_W'(1);
                else
                    lin_q <= lin_q + ADDR_W'(cols_q);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.addr_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start)
                    state_d = zero_size ? DONE : RUN;
            end
            RUN: begin
                bus.addr_valid = 1'b1;
                bus.busy       = 1'b1;
                if (beat && inner_at && outer_at)
                    state_d = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.row_idx  = col_major_q ? inner_count[ROW_W-1:0] : outer_count[ROW_W-1:0];
    assign bus.col_idx  = col_major_q ? outer_count[COL_W-1:0] : inner_count[COL_W-1:0];
    assign bus.lin_addr = lin_q;
    assign bus.row_last = is_run && inner_at;
    assign bus.mat_last = is_run && inner_at && outer_at;
endmodule
